div_unit: RTL and testbench

Iterative multi-cycle divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits in the execute stage beside the single-cycle alu. Takes operands from the same op1/op2 paths and stalls the pipeline through a valid/ready handshake until the result is ready. Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/riscv_types.sv | 33 +++
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 133 +++++++++++++
 tb/tb_div_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_types.sv
// Shared RV32 execute-stage types: ALU op codes, divider op codes and divider FSM states.
package riscv_types;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_t;

   typedef enum logic [1:0] {
      DIV,
      DIVU,
      REM,
      REMU
   } div_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   // rem < divisor always holds, so shifted < 2*divisor and XLEN+1 bits suffice for the sign.
   assign shifted  = {rem, quo[XLEN-1]};
   assign trial    = shifted - {1'b0, divisor};
   assign rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
   assign quo_next = {quo[XLEN-2:0], ~trial[XLEN]};

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle,
// valid/ready handshake on both sides, flushable from any state.
module div_unit
   import riscv_types::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  div_op_t         div_op,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] div_result,
   output logic            busy
);

   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_t      state_q, state_d;
   div_op_t         op_q, op_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] divisor_q, divisor_d;
   logic [CW-1:0]   count_q, count_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;

   logic            signed_op;
   logic            neg1, neg2;
   logic [XLEN-1:0] mag1, mag2;
   logic [XLEN-1:0] step_rem, step_quo;

   assign signed_op = (div_op == DIV) || (div_op == REM);
   assign neg1      = signed_op & op1[XLEN-1];
   assign neg2      = signed_op & op2[XLEN-1];
   assign mag1      = neg1 ? -op1 : op1;
   assign mag2      = neg2 ? -op2 : op2;

   div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (divisor_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         op_q      <= DIV;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         count_q   <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         divisor_q <= divisor_d;
         count_q   <= count_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      count_d   = count_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               op_d      = div_op;
               divisor_d = mag2;
               count_d   = '0;
               neg_quo_d = neg1 ^ neg2;
               neg_rem_d = neg1;
               // Special results are loaded already sign-correct, so FIX is skipped.
               if (op2 == '0) begin
                  quo_d   = '1;
                  rem_d   = op1;
                  state_d = DONE;
               end else if (signed_op && op1 == MIN_NEG && op2 == '1) begin
                  quo_d   = MIN_NEG;
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  quo_d   = mag1;
                  rem_d   = '0;
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            count_d = count_q + 1'b1;
            if (count_q == LAST) state_d = FIX;
         end
         FIX: begin
            if (op_q == DIV && neg_quo_q) quo_d = -quo_q;
            if (op_q == REM && neg_rem_q) rem_d = -rem_q;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign div_result = (op_q == REM || op_q == REMU) ? rem_q : quo_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for results/latency plus hand sequences
// for back-pressure, back-to-back issue, flush and asynchronous reset.
module tb_div_unit;
   import riscv_types::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   div_op_t     div_op;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] div_result;
   logic        busy;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   div_unit #(.XLEN(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .div_op     (div_op),
      .op1        (op1),
      .op2        (op2),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .div_result (div_result),
      .busy       (busy)
   );

   typedef struct {
      div_op_t     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int unsigned lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one op at a negedge; returns after the accept edge (+1).
   task automatic start_op(input string name, input div_op_t op, input logic [31:0] a, input logic [31:0] b);
      int unsigned guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check({name, " ready_wait"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      div_op   = op;
      op1      = a;
      op2      = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op1      = $urandom;
      op2      = $urandom;
      div_op   = REMU;
      check({name, " busy_after_accept"}, 32'(busy), 32'd1);
   endtask

   task automatic run_op(input string name, input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int unsigned exp_lat, input bit consume);
      int unsigned lat;
      start_op(name, op, a, b);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({name, " latency"}, lat, exp_lat);
      check({name, " result"}, div_result, exp);
      check({name, " in_ready_in_done"}, 32'(in_ready), 32'd0);
      if (consume) begin
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
         check({name, " idle_after_consume"}, {30'd0, in_ready, out_valid}, 32'b10);
      end
   endtask

   initial begin
      int unsigned seen;
      vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         34};
      vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          34};
      vecs[2]  = '{DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   34};
      vecs[3]  = '{REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   34};
      vecs[4]  = '{REM,  32'd100,        32'hFFFFFFF9,   32'd2,          34};
      vecs[5]  = '{DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1};
      vecs[6]  = '{REMU, 32'd5,          32'd0,          32'd5,          1};
      vecs[7]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
      vecs[8]  = '{REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
      vecs[9]  = '{DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
      vecs[10] = '{REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1};
      vecs[11] = '{DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   34};
      vecs[12] = '{REM,  32'd7,          32'hFFFFFFFE,   32'd1,          34};
      vecs[13] = '{DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34};
      vecs[14] = '{REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   34};
      vecs[15] = '{DIV,  32'h80000000,   32'd1,          32'h80000000,   34};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      div_op    = DIV;
      op1       = '0;
      op2       = '0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {in_ready, out_valid, busy, 29'd0}, {1'b1, 1'b0, 1'b0, 29'd0});
      check("reset_result", div_result, 32'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++)
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);

      // Back-pressure: result held while out_ready stays low
      run_op("hold", DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("hold%0d valid/ready", i), {30'd0, out_valid, in_ready}, 32'b10);
         check($sformatf("hold%0d result", i), div_result, 32'd14);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("hold release idle", {30'd0, in_ready, out_valid}, 32'b10);
      run_op("b2b", REMU, 32'd100, 32'd7, 32'd2, 34, 1'b1);

      // flush together with in_valid in IDLE: not accepted
      @(negedge clk);
      in_valid = 1'b1;
      flush    = 1'b1;
      div_op   = DIVU;
      op1      = 32'd9;
      op2      = 32'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flush_vs_accept", {30'd0, in_ready, busy}, 32'b10);

      // flush mid-CALC at count 15
      start_op("flush", DIVU, 32'd1000, 32'd3);
      repeat (15) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush idle", {29'd0, in_ready, busy, out_valid}, 32'b100);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flush no out_valid", seen, 0);
      run_op("after_flush", DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34, 1'b1);

      // Asynchronous reset between edges mid-CALC
      start_op("areset", DIV, 32'd12345, 32'd67);
      repeat (10) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("areset outputs", {29'd0, in_ready, out_valid, busy}, 32'b100);
      check("areset result", div_result, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) seen++;
      end
      check("areset no stale", seen, 0);
      run_op("after_reset", DIV, 32'd12345, 32'd67, 32'd184, 34, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
